// File: rtl/sub9bits_serial.sv
// Bit-serial 9-bit subtractor: D = A - B one bit per clock, LSB first.
// start/done handshake; D[9] carries the borrow-out unless stop forces it low.
module sub9bits_serial (
   input  logic       clk,
   input  logic       Reset,
   input  logic       start,
   input  logic [8:0] A,
   input  logic [8:0] B,
   input  logic       stop,
   output logic       busy,
   output logic       done,
   output logic [9:0] D
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [8:0]  ra_q;
   logic [8:0]  rb_q;
   logic [7:0]  rd_q;
   logic        bw_q;
   logic [3:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [9:0]  d_q;

   logic        diff_bit_d;
   logic        bw_d;
   logic [8:0]  rd_d;

   // One full-subtractor bit slice plus the result shift register's next value
   always_comb begin
      diff_bit_d = ra_q[0] ^ rb_q[0] ^ bw_q;
      bw_d       = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bw_q);
      rd_d       = {diff_bit_d, rd_q};
   end

   // Control FSM, operand/result shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         ra_q    <= 9'd0;
         rb_q    <= 9'd0;
         rd_q    <= 8'd0;
         bw_q    <= 1'b0;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         d_q     <= 10'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  ra_q    <= A;
                  rb_q    <= B;
                  rd_q    <= 8'd0;
                  bw_q    <= 1'b0;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               ra_q   <= {1'b0, ra_q[8:1]};
               rb_q   <= {1'b0, rb_q[8:1]};
               rd_q   <= rd_d[8:1];
               bw_q   <= bw_d;
               cnt_q  <= cnt_q + 4'd1;
               busy_q <= 1'b1;
               // The ninth bit completes the word; stop is only honoured here
               if (cnt_q == 4'd8) begin
                  d_q     <= {(stop ? 1'b0 : bw_d), rd_d};
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  done_q  <= 1'b0;
                  state_q <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign D    = d_q;

endmodule
